// File: rtl/ram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_arb_pkg : shared types and defaults for the RAM port arbiter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ram_arb_pkg;

    localparam int c_DEF_AW     = 16;
    localparam int c_DEF_DW     = 16;
    localparam int c_DEF_RD_LAT = 2;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    localparam rd_tag_t c_TAG_EMPTY = '{valid: 1'b0, owner: OWN_M0};

    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic [7:0] limit);
        return (value >= limit) ? limit : 8'(value + 8'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rd_tag_pipe : RD_LAT-deep shift register of read ownership tags       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = c_DEF_RD_LAT
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t [RD_LAT-1:0] r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= c_TAG_EMPTY;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_port_arbiter : fixed-priority RAM port share with m1 starve guard |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = c_DEF_AW,
    parameter int DW       = c_DEF_DW,
    parameter int RD_LAT   = c_DEF_RD_LAT,
    parameter int MAX_WAIT = 8
) (
    input  logic          clock,
    input  logic          reset_n,

    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_wren,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_wren,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] ram_address,
    output logic          ram_wren,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q
);

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0]    r_wait_cnt;
    logic [AW-1:0] r_addr_hold;
    logic [DW-1:0] r_data_hold;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic          w_force1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_wren;
    rd_tag_t       w_new_tag;
    rd_tag_t       w_tail_tag;

    // Grants are masked by reset so nothing reaches the RAM while held in reset.
    assign w_force1 = (r_wait_cnt == c_MAX_WAIT);
    assign w_gnt1   = reset_n & m1_req & (w_force1 | ~m0_req);
    assign w_gnt0   = reset_n & m0_req & ~w_gnt1;

    always_comb begin
        w_addr = r_addr_hold;
        w_data = r_data_hold;
        w_wren = 1'b0;
        if (w_gnt1) begin
            w_addr = m1_addr;
            w_data = m1_wdata;
            w_wren = m1_wren;
        end else if (w_gnt0) begin
            w_addr = m0_addr;
            w_data = m0_wdata;
            w_wren = m0_wren;
        end
    end

    always_comb begin
        w_new_tag       = c_TAG_EMPTY;
        w_new_tag.valid = (w_gnt0 | w_gnt1) & ~w_wren;
        w_new_tag.owner = w_gnt1 ? OWN_M1 : OWN_M0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt  <= 8'd0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else begin
            if (m1_req && !w_gnt1) begin
                r_wait_cnt <= sat_inc(r_wait_cnt, c_MAX_WAIT);
            end else begin
                r_wait_cnt <= 8'd0;
            end
            r_addr_hold <= w_addr;
            r_data_hold <= w_data;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk   (clock),
        .rst_n (reset_n),
        .i_tag (w_new_tag),
        .o_tag (w_tail_tag)
    );

    assign m0_rvalid = w_tail_tag.valid & (w_tail_tag.owner == OWN_M0);
    assign m1_rvalid = w_tail_tag.valid & (w_tail_tag.owner == OWN_M1);
    assign m0_rdata  = m0_rvalid ? ram_q : r_m0_rdata;
    assign m1_rdata  = m1_rvalid ? ram_q : r_m1_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            r_m0_rdata <= m0_rdata;
            r_m1_rdata <= m1_rdata;
        end
    end

    assign m0_gnt      = w_gnt0;
    assign m1_gnt      = w_gnt1;
    assign ram_address = w_addr;
    assign ram_data    = w_data;
    assign ram_wren    = w_wren;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_port_arbiter : directed self-checking bench with RAM model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m0_wren = 1'b0;
    logic [15:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_gnt, m0_rvalid;
    logic [15:0] m0_rdata;
    logic        m1_req = 1'b0, m1_wren = 1'b0;
    logic [15:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_gnt, m1_rvalid;
    logic [15:0] m1_rdata;
    logic [15:0] ram_address, ram_data;
    logic        ram_wren;
    logic [15:0] ram_q = '0;
    logic [15:0] r_q1 = '0;
    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ram_port_arbiter #(
        .AW(16), .DW(16), .RD_LAT(2), .MAX_WAIT(8)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wren(m0_wren), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wren(m1_wren), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q)
    );

    // Two-cycle registered-output RAM, read-after-write on the same port.
    always @(posedge clock) begin
        r_q1  <= mem[ram_address];
        ram_q <= r_q1;
        if (ram_wren) mem[ram_address] = ram_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_m0(input logic req, input logic [15:0] a, input logic wr, input logic [15:0] d);
        m0_req = req; m0_addr = a; m0_wren = wr; m0_wdata = d;
    endtask

    task automatic drive_m1(input logic req, input logic [15:0] a, input logic wr, input logic [15:0] d);
        m1_req = req; m1_addr = a; m1_wren = wr; m1_wdata = d;
    endtask

    initial begin
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0100] = 16'h1111;
        mem[16'h0200] = 16'h2222;
        mem[16'h0005] = 16'h0000;

        // Reset with both requesters active
        drive_m0(1'b1, 16'h0010, 1'b0, 16'h0);
        drive_m1(1'b1, 16'h0100, 1'b0, 16'h0);
        @(negedge clock); #1;
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_ram_wren", ram_wren, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        @(negedge clock);

        // Release: m0 wins the first cycle, single read of 0x0010
        reset_n = 1'b1; #1;
        check("rel_m0_gnt", m0_gnt, 1);
        check("rel_m1_gnt", m1_gnt, 0);
        check("rel_ram_address", ram_address, 16'h0010);
        @(negedge clock);
        drive_m0(1'b0, 16'h0, 1'b0, 16'h0);
        drive_m1(1'b0, 16'h0, 1'b0, 16'h0);
        #1;
        check("rd1_m0_rvalid_early", m0_rvalid, 0);
        @(negedge clock); #1;
        check("rd1_m0_rvalid", m0_rvalid, 1);
        check("rd1_m0_rdata", m0_rdata, 16'hBEEF);
        check("rd1_m1_rvalid", m1_rvalid, 0);
        @(negedge clock); #1;
        check("rd1_m0_rvalid_once", m0_rvalid, 0);
        check("rd1_m0_rdata_hold", m0_rdata, 16'hBEEF);
        check("idle_ram_address_hold", ram_address, 16'h0010);
        check("idle_ram_wren", ram_wren, 0);

        // Interleaved returns: m1 at t, m0 at t+1
        @(negedge clock);
        drive_m1(1'b1, 16'h0100, 1'b0, 16'h0); #1;
        check("il_m1_gnt", m1_gnt, 1);
        @(negedge clock);
        drive_m1(1'b0, 16'h0, 1'b0, 16'h0);
        drive_m0(1'b1, 16'h0200, 1'b0, 16'h0); #1;
        check("il_m0_gnt", m0_gnt, 1);
        @(negedge clock);
        drive_m0(1'b0, 16'h0, 1'b0, 16'h0); #1;
        check("il_m1_rvalid", m1_rvalid, 1);
        check("il_m1_rdata", m1_rdata, 16'h1111);
        check("il_m0_rvalid_t2", m0_rvalid, 0);
        @(negedge clock); #1;
        check("il_m0_rvalid", m0_rvalid, 1);
        check("il_m0_rdata", m0_rdata, 16'h2222);
        check("il_m1_rvalid_t3", m1_rvalid, 0);

        // Write by m1 then read-back by m0
        @(negedge clock);
        drive_m1(1'b1, 16'h0005, 1'b1, 16'h00A5); #1;
        check("wr_m1_gnt", m1_gnt, 1);
        check("wr_ram_wren", ram_wren, 1);
        check("wr_ram_data", ram_data, 16'h00A5);
        @(negedge clock);
        drive_m1(1'b0, 16'h0, 1'b0, 16'h0);
        drive_m0(1'b1, 16'h0005, 1'b0, 16'h0); #1;
        check("wr_rd_ram_wren", ram_wren, 0);
        check("wr_rd_m0_gnt", m0_gnt, 1);
        @(negedge clock);
        drive_m0(1'b0, 16'h0, 1'b0, 16'h0); #1;
        check("wr_no_m1_rvalid", m1_rvalid, 0);
        check("wr_no_m0_rvalid", m0_rvalid, 0);
        @(negedge clock); #1;
        check("wr_rd_m0_rvalid", m0_rvalid, 1);
        check("wr_rd_m0_rdata", m0_rdata, 16'h00A5);
        @(negedge clock);
        @(negedge clock);

        // Contention: both held, m1 forced every 9th cycle
        for (int k = 0; k < 18; k++) begin
            @(negedge clock);
            if (k == 0) begin
                drive_m0(1'b1, 16'h0010, 1'b0, 16'h0);
                drive_m1(1'b1, 16'h0100, 1'b0, 16'h0);
            end
            #1;
            check("cont_m1_gnt", m1_gnt, (k % 9) == 8);
            check("cont_m0_gnt", m0_gnt, (k % 9) != 8);
            if (k >= 2) begin
                check("cont_m1_rvalid", m1_rvalid, ((k - 2) % 9) == 8);
                check("cont_m0_rvalid", m0_rvalid, ((k - 2) % 9) != 8);
            end
            if (k == 10) check("cont_m1_rdata", m1_rdata, 16'h1111);
            if (k == 5)  check("cont_m0_rdata", m0_rdata, 16'hBEEF);
        end
        @(negedge clock);
        drive_m0(1'b0, 16'h0, 1'b0, 16'h0);
        drive_m1(1'b0, 16'h0, 1'b0, 16'h0);
        repeat (3) @(negedge clock);

        // Reset in the middle of an outstanding m0 read
        drive_m0(1'b1, 16'h0200, 1'b0, 16'h0); #1;
        check("mf_m0_gnt", m0_gnt, 1);
        @(negedge clock);
        drive_m0(1'b0, 16'h0, 1'b0, 16'h0);
        reset_n = 1'b0; #1;
        check("mf_rst_m0_rvalid", m0_rvalid, 0);
        check("mf_rst_m0_rdata", m0_rdata, 0);
        check("mf_rst_ram_address", ram_address, 0);
        @(negedge clock);
        reset_n = 1'b1; #1;
        check("mf_t2_m0_rvalid", m0_rvalid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            check("mf_late_m0_rvalid", m0_rvalid, 0);
            check("mf_late_m1_rvalid", m1_rvalid, 0);
        end

        // Starve counter must start from zero after the reset
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            if (k == 0) begin
                drive_m0(1'b1, 16'h0010, 1'b0, 16'h0);
                drive_m1(1'b1, 16'h0100, 1'b0, 16'h0);
            end
            #1;
            check("post_rst_m1_gnt", m1_gnt, k == 8);
        end
        @(negedge clock);
        drive_m0(1'b0, 16'h0, 1'b0, 16'h0);
        drive_m1(1'b0, 16'h0, 1'b0, 16'h0);
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
